vector_sweep_gen: RTL and testbench

VECTOR_SWEEP_GEN -- requirements
Module: vector_sweep_gen

---
 rtl/vector_sweep_gen_if.sv | 30 +++
 rtl/vector_sweep_gen.sv | 114 +++++++++++
 tb/tb_vector_sweep_gen.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/vector_sweep_gen_if.sv
// Bus bundle for vector_sweep_gen: sweep control, driven vector, captured table.
// Optional compare signals exist only when SWEEP_COMPARE_EN is defined.
interface vector_sweep_gen_if;
  logic        start;
  logic        abort;
  logic        f_in;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic [3:0]  vec_idx;
  logic        busy;
  logic        done;
  logic [15:0] tt_out;
`ifdef SWEEP_COMPARE_EN
  logic [15:0] expected;
  logic [4:0]  mismatch_cnt;
  logic        pass;

  modport master (input start, abort, f_in, expected,
                  output a, b, c, d, vec_idx, busy, done, tt_out, mismatch_cnt, pass);
  modport slave  (output start, abort, f_in, expected,
                  input a, b, c, d, vec_idx, busy, done, tt_out, mismatch_cnt, pass);
`else
  modport master (input start, abort, f_in,
                  output a, b, c, d, vec_idx, busy, done, tt_out);
  modport slave  (output start, abort, f_in,
                  input a, b, c, d, vec_idx, busy, done, tt_out);
`endif
endinterface

// File: rtl/vector_sweep_gen.sv
// Sweeps a 4-bit input vector 0..15, holding each for HOLD_CYCLES, and records f_in per vector.
// Define SWEEP_COMPARE_EN to add the expected-table compare (mismatch_cnt, pass).
//
// state | meaning
// IDLE  | waiting for start; vector driven to 0, last table held
// DRIVE | holding a vector, sampling f_in on the last hold cycle
// DONE  | one-cycle completion pulse, then back to IDLE
module vector_sweep_gen #(
  parameter int HOLD_CYCLES = 20
) (
  input logic             clk,
  input logic             rst_n,
  vector_sweep_gen_if.master bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  hold_cnt;
  logic [3:0]  vec;
  logic [15:0] tt;
  logic        busy_q;
  logic        done_q;
  logic        launch;
  logic        last_hold;
  logic        sample;

  assign launch    = (state == IDLE) && bus.start && !bus.abort;
  assign last_hold = (state == DRIVE) && (hold_cnt == HOLD_LAST);
  assign sample    = last_hold && !bus.abort;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = DRIVE;
      DRIVE: begin
        if (bus.abort)                    state_nxt = IDLE;
        else if (last_hold && vec == 4'hF) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Vector returns to 0 on abort and on completion so IDLE always drives 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      vec      <= '0;
      tt       <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= (state_nxt == DRIVE);
      done_q <= (state_nxt == DONE);
      if (launch) begin
        hold_cnt <= '0;
        vec      <= '0;
        tt       <= '0;
      end else if (state == DRIVE) begin
        if (bus.abort) begin
          hold_cnt <= '0;
          vec      <= '0;
        end else if (last_hold) begin
          hold_cnt <= '0;
          tt[vec]  <= bus.f_in;
          vec      <= (vec == 4'hF) ? 4'h0 : vec + 4'd1;
        end else begin
          hold_cnt <= hold_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.a       = vec[3];
  assign bus.b       = vec[2];
  assign bus.c       = vec[1];
  assign bus.d       = vec[0];
  assign bus.vec_idx = vec;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.tt_out  = tt;

`ifdef SWEEP_COMPARE_EN
  logic [4:0] mis_cnt;
  logic       pass_q;

  // pass is judged in DONE, when the last sample has already been counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_cnt <= '0;
      pass_q  <= 1'b0;
    end else if (launch) begin
      mis_cnt <= '0;
      pass_q  <= 1'b0;
    end else begin
      if (sample && (bus.f_in != bus.expected[vec])) mis_cnt <= mis_cnt + 5'd1;
      if (state == DONE) pass_q <= (mis_cnt == 5'd0);
    end
  end

  assign bus.mismatch_cnt = mis_cnt;
  assign bus.pass         = pass_q;
`endif

endmodule

// File: tb/tb_vector_sweep_gen.sv
// Directed bench for vector_sweep_gen: HOLD_CYCLES=20 and HOLD_CYCLES=1 instances on one clock.
// Compare-feature checks compile in when SWEEP_COMPARE_EN is defined.
module tb_vector_sweep_gen;

  logic clk;
  logic rst_n;
  logic f_mode;
  int   n_tests;
  int   n_fail;

  vector_sweep_gen_if ia ();
  vector_sweep_gen_if ib ();

  vector_sweep_gen #(.HOLD_CYCLES(20)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  vector_sweep_gen #(.HOLD_CYCLES(1))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  assign ia.f_in = f_mode ? ~ia.a : (ia.a & ia.b);
  assign ib.f_in = ib.c ^ ib.d;
`ifdef SWEEP_COMPARE_EN
  assign ib.expected = 16'h6666;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_abcd"}, 32'({ia.a, ia.b, ia.c, ia.d}), 32'h0);
    chk({tag, "_vec"},  32'(ia.vec_idx), 32'h0);
    chk({tag, "_busy"}, 32'(ia.busy), 32'h0);
    chk({tag, "_done"}, 32'(ia.done), 32'h0);
  endtask

  // Pulses start on dut_a; returns the 1-based cycle in which done was seen (0 = never).
  task automatic sweep_a(output int done_cyc);
    done_cyc = 0;
    @(negedge clk) ia.start = 1'b1;
    @(posedge clk);
    @(negedge clk) ia.start = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == 1) chk("a_busy_first", 32'(ia.busy), 32'h1);
      if (cyc <= 320 && (cyc - 1) % 20 == 0)
        chk("a_vec_step", 32'({ia.a, ia.b, ia.c, ia.d}), 32'((cyc - 1) / 20));
      if (ia.done) begin
        done_cyc = cyc;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int dc;
    int busy_cnt;
    int done_cnt;
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    f_mode   = 1'b0;
    ia.start = 1'b0;
    ia.abort = 1'b0;
    ib.start = 1'b0;
    ib.abort = 1'b0;
`ifdef SWEEP_COMPARE_EN
    ia.expected = 16'hF000;
`endif

    #12;
    chk_idle_a("rst");
    chk("rst_tt", 32'(ia.tt_out), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(ia.busy), 32'h0);

    // H=20, f=a&b
    sweep_a(dc);
    chk("a_done_cyc", 32'(dc), 32'd321);
    chk("a_tt", 32'(ia.tt_out), 32'hF000);
    chk_idle_a("a_after");
`ifdef SWEEP_COMPARE_EN
    chk("a_pass", 32'(ia.pass), 32'h1);
    chk("a_mis", 32'(ia.mismatch_cnt), 32'h0);
`endif

    // H=1, f=c^d, start held through DRIVE and DONE
    dc = 0;
    busy_cnt = 0;
    @(negedge clk) ib.start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (ib.busy) busy_cnt++;
      if (cyc <= 16) chk("b_vec", 32'(ib.vec_idx), 32'(cyc - 1));
      if (ib.done && dc == 0) dc = cyc;
      if (dc != 0 && cyc == dc + 1) begin
        chk("b_no_restart", 32'(ib.busy), 32'h0);
        ib.start = 1'b0;
      end
    end
    ib.start = 1'b0;
    chk("b_done_cyc", 32'(dc), 32'd17);
    chk("b_busy_cnt", 32'(busy_cnt), 32'd16);
    chk("b_tt", 32'(ib.tt_out), 32'h6666);
`ifdef SWEEP_COMPARE_EN
    chk("b_pass", 32'(ib.pass), 32'h1);
`endif

    // abort at vec_idx=5, f=~a
    f_mode = 1'b1;
    @(negedge clk) ia.start = 1'b1;
    @(negedge clk) ia.start = 1'b0;
    dc = 0;
    for (int i = 0; i < 300; i++) begin
      if (ia.vec_idx == 4'd5) begin
        dc = 1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_reach5", 32'(dc), 32'h1);
    ia.abort = 1'b1;
    @(negedge clk) ia.abort = 1'b0;
    chk_idle_a("abort");
    chk("abort_tt", 32'(ia.tt_out), 32'h001F);
    done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ia.done || ia.busy) done_cnt++;
    end
    chk("abort_quiet", 32'(done_cnt), 32'h0);

    // start and abort together in IDLE: abort wins
    ia.start = 1'b1;
    ia.abort = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    ia.abort = 1'b0;
    chk("start_abort_busy", 32'(ia.busy), 32'h0);
    chk("start_abort_tt", 32'(ia.tt_out), 32'h001F);

    // reset at vec_idx=9
    f_mode = 1'b0;
    @(negedge clk) ia.start = 1'b1;
    @(negedge clk) ia.start = 1'b0;
    dc = 0;
    for (int i = 0; i < 300; i++) begin
      if (ia.vec_idx == 4'd9) begin
        dc = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_reach9", 32'(dc), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_a("midrst");
    chk("midrst_tt", 32'(ia.tt_out), 32'h0);
`ifdef SWEEP_COMPARE_EN
    chk("midrst_mis", 32'(ia.mismatch_cnt), 32'h0);
    chk("midrst_pass", 32'(ia.pass), 32'h0);
`endif
    @(negedge clk) rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ia.done || ia.busy) done_cnt++;
    end
    chk("midrst_no_resume", 32'(done_cnt), 32'h0);

`ifdef SWEEP_COMPARE_EN
    ia.expected = 16'hF001;
    sweep_a(dc);
    chk("cmp_done_cyc", 32'(dc), 32'd321);
    chk("cmp_pass", 32'(ia.pass), 32'h0);
    chk("cmp_mis", 32'(ia.mismatch_cnt), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
